alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the BitBlaster datapath; next generation of the A/G staged ALU.
//  Stages operand A, executes FN against bus operand OP, drives result onto shared bus via Gout.
//  Adds start/busy/done handshake, iterative barrel-free shifter, and Z/N/C/V status flags.
//  Sits between register-file bus and controller FSM; controller stalls on busy.
// PARAMETERS
//  WIDTH       10  datapath width (>=4)
//  SHIFT_STEP  1   bits shifted per cycle for LSL/LSR/ASR (1,2,4; power of 2, <=WIDTH)
// PORTS
//  CLKb   in   1      clock; all state updates on negedge CLKb
//  RSTb   in   1      asynchronous active-low reset
//  OP     in   WIDTH  bus operand (Ry, switch data, or zero-padded immediate)
//  FN     in   4      opcode, alu_pkg::alu_fn_e
//  Ain    in   1      load A <= OP at edge
//  Gin    in   1      start operation FN at edge (ignored while busy)
//  Gout   in   1      drive G onto RES
//  RES    out  WIDTH  Gout ? G : 'z
//  busy   out  1      multi-cycle shift in progress
//  done   out  1      one-cycle pulse: G/flags updated on the previous edge
//  flags  out  4      {Z,N,C,V} of last completed result
// BEHAVIOUR
//  Reset (async, RSTb=0): A=0, G=0, flags=0, busy=0, done=0, state=IDLE, count=0.
//  FSM states: IDLE, SHIFT.
//  IDLE, Gin=1, single-cycle FN: G and flags written that edge; done=1 next cycle; stays IDLE.
//   LOAD,COPY: OP. ADD/ADDI: A+OP. SUB/SUBI: A-OP. INV: -OP (two's complement). FLIP: ~OP.
//   AND/OR/XOR: A op OP. Undefined FN: G=0, flags={1,0,0,0}, done still pulses.
//  IDLE, Gin=1, shift FN: amount n = min(OP, WIDTH) (unsigned); work<=A, cnt<=n.
//   n==0: G<=A, C=0, done next cycle, stay IDLE.
//   else -> SHIFT, busy=1; each edge shifts work by min(SHIFT_STEP, cnt), cnt-=that.
//   Edge where cnt reaches 0: G<=work result, flags updated, busy=0, done=1 next cycle, -> IDLE.
//   Latency = ceil(n/SHIFT_STEP) edges after Gin edge. LSR fills 0, ASR fills work[WIDTH-1].
//  Flags: Z=(G==0); N=G[WIDTH-1].
//   ADD: C=carry out, V=signed overflow. SUB: C=borrow (A<OP unsigned), V=signed overflow.
//   INV: C=(OP!=0), V=(OP==100..0). Shifts: C=last bit shifted out, V=0. Others: C=V=0.
//  Arithmetic wraps modulo 2^WIDTH; carries computed on WIDTH+1 bits.
//  While busy: Gin ignored (no queueing); Ain still loads A (does not affect the running shift).
//  Ain and Gin at same edge: operation uses OLD A; A takes OP afterwards.
//  Gout purely combinational; independent of busy (drives stale G mid-shift).
//  done never asserted with busy; back-to-back Gin in IDLE gives back-to-back done pulses.
//  Reset mid-SHIFT: abort, all registers to reset values, no done pulse.
// STRUCTURE
//  alu_pkg: alu_fn_e (LOAD=0..SUBI=13, same encoding as the ISA), flag index localparams
//   FLAG_Z/N/C/V, state enum alu_state_e, is_shift(fn) function.
//  Sub-module alu_core_comb: combinational single-cycle ops + flag generation, param WIDTH.
//  Top alu_seq: A reg, G/flags regs, FSM, shift counter/work reg, tri-state RES.
// TESTING (WIDTH=10, SHIFT_STEP=1 unless noted)
//  1 A=0x3FF, ADD OP=0x001 -> G=0x000, flags Z=1,N=0,C=1,V=0; done 1 cycle after Gin edge, busy 0.
//  2 A=0x005, SUB OP=0x007 -> G=0x3FE, Z=0,N=1,C=1,V=0; A=0x1FF ADD 1 -> G=0x200, V=1.
//  3 A=0x001, LSL OP=3 -> busy 3 cycles, G=0x008, C=0, done after 3rd edge; Gin mid-shift ignored.
//  4 A=0x200, ASR OP=12 -> clamped to 10, busy 10 cycles, G=0x3FF, N=1; SHIFT_STEP=4 -> 3 cycles.
//  5 LSR A=0x3FF by 6, RSTb=0 at 2nd busy cycle -> G=0, flags=0, busy=0, no done pulse.
//  6 Gout=0 -> RES=z; Ain&Gin same edge with A=2, OP=3, ADD -> G=5, then A=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the BitBlaster staged ALU: opcodes, status-flag indices, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // Opcode encoding matches the ISA; 14 and 15 are undefined.
    typedef enum logic [3:0] {
        LOAD = 4'd0,
        COPY = 4'd1,
        ADD  = 4'd2,
        SUB  = 4'd3,
        INV  = 4'd4,
        FLIP = 4'd5,
        AND  = 4'd6,
        OR   = 4'd7,
        XOR  = 4'd8,
        LSL  = 4'd9,
        LSR  = 4'd10,
        ASR  = 4'd11,
        ADDI = 4'd12,
        SUBI = 4'd13
    } alu_fn_e;

    // Bit positions inside the {Z,N,C,V} flags vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] fn);
        return (fn == LSL) || (fn == LSR) || (fn == ASR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/control/status bundle between controller, register-file bus and alu_seq.
// Latency: n/a (wiring only).
// Backpressure: busy tells the controller to stall; Gin is dropped while busy.
//  OP/FN/Ain/Gin/Gout : controller -> ALU      busy/done/flags : ALU -> controller
interface alu_seq_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] OP;
    logic [3:0]       FN;
    logic             Ain;
    logic             Gin;
    logic             Gout;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output OP, FN, Ain, Gin, Gout,
        input  busy, done, flags
    );

    modport slave (
        input  OP, FN, Ain, Gin, Gout,
        output busy, done, flags
    );
endinterface

// File: rtl/alu_core_comb.sv
// Single-cycle ALU ops and {Z,N,C,V} generation; shift opcodes are handled by the caller.
// Latency: combinational.
// Backpressure: none.
//  fn/a/op in, res/flg out. Undefined opcodes give res=0, which yields flags {1,0,0,0}.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [3:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flg
);
    // One extra bit so the MSB is the carry (add) or borrow (sub).
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    logic           c;
    logic           v;

    assign sum = {1'b0, a} + {1'b0, op};
    assign dif = {1'b0, a} - {1'b0, op};

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (fn)
            LOAD, COPY: res = op;
            ADD, ADDI: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            SUB, SUBI: begin
                res = dif[WIDTH-1:0];
                c   = dif[WIDTH];
                v   = (a[WIDTH-1] != op[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            INV: begin
                res = '0 - op;
                c   = (op != '0);
                v   = (op == {1'b1, {(WIDTH-1){1'b0}}});
            end
            FLIP:    res = ~op;
            AND:     res = a & op;
            OR:      res = a | op;
            XOR:     res = a ^ op;
            default: res = '0;
        endcase

        flg         = '0;
        flg[FLAG_Z] = (res == '0);
        flg[FLAG_N] = res[WIDTH-1];
        flg[FLAG_C] = c;
        flg[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_seq.sv
// Staged multi-cycle ALU: A register, result G with flags, iterative shifter, tri-state result.
// Latency: 1 edge for single-cycle ops; ceil(min(OP,WIDTH)/SHIFT_STEP) edges for shifts.
// Backpressure: busy high during a shift; Gin ignored (not queued) until busy drops.
//  CLKb/RSTb plain (negedge clock, async active-low reset); bus = alu_seq_if.slave; RES = Gout ? G : 'z.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int SHIFT_STEP = 1
) (
    input  logic             CLKb,
    input  logic             RSTb,
    alu_seq_if.slave         bus,
    output wire [WIDTH-1:0]  RES
);
    localparam int CW = $clog2(WIDTH + 1);

    alu_state_e       state_q, state_n;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] g_q, g_n;
    logic [3:0]       flags_q, flags_n;
    logic             done_q, done_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] work_q, work_n;
    logic [3:0]       sfn_q, sfn_n;

    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flg;
    logic [CW-1:0]    n_amt;
    logic [CW-1:0]    sh_step;
    logic [WIDTH-1:0] sh_work;
    logic             sh_c;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .fn  (bus.FN),
        .a   (a_q),
        .op  (bus.OP),
        .res (core_res),
        .flg (core_flg)
    );

    // Shift distance saturates at WIDTH; anything larger shifts everything out.
    assign n_amt   = (bus.OP > WIDTH'(WIDTH)) ? CW'(WIDTH) : bus.OP[CW-1:0];
    assign sh_step = (cnt_q < CW'(SHIFT_STEP)) ? cnt_q : CW'(SHIFT_STEP);

    // Up to SHIFT_STEP single-bit shifts per edge, stopping when the count runs out.
    // The carry ends up holding the last bit pushed off the end.
    always_comb begin
        sh_work = work_q;
        sh_c    = 1'b0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (CW'(i) < cnt_q) begin
                case (sfn_q)
                    LSL: begin
                        sh_c    = sh_work[WIDTH-1];
                        sh_work = {sh_work[WIDTH-2:0], 1'b0};
                    end
                    LSR: begin
                        sh_c    = sh_work[0];
                        sh_work = {1'b0, sh_work[WIDTH-1:1]};
                    end
                    ASR: begin
                        sh_c    = sh_work[0];
                        sh_work = {sh_work[WIDTH-1], sh_work[WIDTH-1:1]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_n = state_q;
        g_n     = g_q;
        flags_n = flags_q;
        done_n  = 1'b0;
        cnt_n   = cnt_q;
        work_n  = work_q;
        sfn_n   = sfn_q;
        case (state_q)
            IDLE: begin
                if (bus.Gin) begin
                    if (is_shift(bus.FN)) begin
                        work_n = a_q;
                        cnt_n  = n_amt;
                        sfn_n  = bus.FN;
                        if (n_amt == '0) begin
                            // Zero-distance shift completes immediately with C=0.
                            g_n     = a_q;
                            flags_n = {(a_q == '0), a_q[WIDTH-1], 2'b00};
                            done_n  = 1'b1;
                        end else begin
                            state_n = SHIFT;
                        end
                    end else begin
                        g_n     = core_res;
                        flags_n = core_flg;
                        done_n  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_n = sh_work;
                cnt_n  = cnt_q - sh_step;
                if (cnt_n == '0) begin
                    g_n     = sh_work;
                    flags_n = {(sh_work == '0), sh_work[WIDTH-1], sh_c, 1'b0};
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= IDLE;
            g_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            sfn_q   <= '0;
        end else begin
            state_q <= state_n;
            g_q     <= g_n;
            flags_q <= flags_n;
            done_q  <= done_n;
            cnt_q   <= cnt_n;
            work_q  <= work_n;
            sfn_q   <= sfn_n;
        end
    end

    // A loads in any state; a same-edge operation has already sampled the old value.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            a_q <= '0;
        end else if (bus.Ain) begin
            a_q <= bus.OP;
        end
    end

    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = done_q;
    assign bus.flags = flags_q;

    // Drives whatever G holds, including a stale value while a shift is running.
    assign RES = bus.Gout ? g_q : {WIDTH{1'bz}};
endmodule
